// File: rtl/la_rrmux.sv
// la_rrmux: N-input registered round-robin mux, valid/ready on every port, winning index carried in out_sel.
// Build option: define LA_RRMUX_SKID_EN for a two-entry buffer that removes the out_ready -> in_ready path.
module la_rrmux #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter     PROP = "DEFAULT",
  localparam int SW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [SW-1:0] r_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;

  logic          w_grant_any;
  logic [SW-1:0] w_grant;
  logic          w_accept;
  logic          w_in_xfer;
  logic [W-1:0]  w_in_word;
  int            w_idx;

  // Scan ptr, ptr+1, ... wrapping at N; the first valid channel wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_grant_any = 1'b0;
    w_grant     = '0;
    w_idx       = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_grant_any && in_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant     = w_idx[SW-1:0];
      end
    end
  end

  assign w_in_word = in_data[int'(w_grant)*W +: W];
  assign w_in_xfer = w_grant_any & w_accept & ~reset;

  always_comb begin
    in_ready = '0;
    if (w_in_xfer) in_ready[w_grant] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_in_xfer) begin
      r_ptr <= (int'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;
    end
  end

`ifdef LA_RRMUX_SKID_EN
  logic          r_skid_valid;
  logic [W-1:0]  r_skid_data;
  logic [SW-1:0] r_skid_sel;
  logic          w_out_free;

  assign w_accept   = ~r_skid_valid;
  assign w_out_free = ~r_out_valid | out_ready;

  // A parked skid word always refills the output before any new input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_sel    <= r_skid_sel;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_in_word;
        r_out_sel   <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid_valid <= 1'b1;
    end
  end

  // NOTE: skid payload needs no reset; it is only ever read while r_skid_valid is set.
  always_ff @(posedge clk) begin
    if (w_in_xfer && !w_out_free) begin
      r_skid_data <= w_in_word;
      r_skid_sel  <= w_grant;
    end
  end
`else
  assign w_accept = ~r_out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_in_word;
      r_out_sel   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_la_rrmux.sv
// Scoreboard bench for la_rrmux: a transaction-level model predicts grants and buffered words,
// and a negedge monitor compares the DUT outputs against the expected-word queue.
module tb_la_rrmux;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
`ifdef LA_RRMUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic           out_ready = 1'b0;
  wire  [N-1:0]   in_ready;
  wire            out_valid;
  wire  [W-1:0]   out_data;
  wire  [SW-1:0]  out_sel;

  la_rrmux #(.N(N), .W(W), .PROP("DEFAULT")) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [W-1:0] data; int ch; } word_t;
  word_t exp_q[$];
  int    m_ptr, m_cnt, m_last_ch;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit can_accept(input int cnt, input logic ordy);
    return (DEPTH == 2) ? (cnt < 2) : (cnt == 0 || ordy);
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    bit ox;
    if (reset) begin
      m_ptr = 0; m_cnt = 0; m_last_ch = -1;
      exp_q.delete();
    end else begin
      g  = pick(in_valid, m_ptr);
      ox = (m_cnt > 0) && out_ready;
      m_last_ch = -1;
      if (g >= 0 && can_accept(m_cnt, out_ready)) begin
        exp_q.push_back('{in_data[g*W +: W], g});
        m_ptr = (g + 1) % N;
        m_last_ch = g;
        m_cnt++;
      end
      if (ox) m_cnt--;
    end
  end

  // ---------------- monitor ----------------
  logic [SW-1:0] sel_log[$];
  logic [W-1:0]  data_log[$];
  int            popped = 0;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    if (reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
    end else begin
      exp_rdy = '0;
      g = pick(in_valid, m_ptr);
      if (g >= 0 && can_accept(m_cnt, out_ready)) exp_rdy[g] = 1'b1;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, m_cnt > 0);
      if (m_cnt > 0 && exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0].data);
        check("out_sel", out_sel, exp_q[0].ch);
        if (out_ready) begin
          sel_log.push_back(out_sel);
          data_log.push_back(out_data);
          popped++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int fair_sel[6];
    int wrap_sel[4];
    int issued[N];
    int next_seq[N];
    int base_cnt, acc, g0, c;
    fair_sel = '{0, 1, 2, 3, 0, 1};
    wrap_sel = '{3, 1, 3, 1};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b0;

    // Fairness: all channels valid, first grant after reset is channel 0.
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'hA0 + i);
    in_valid = '1;
    out_ready = 1'b1;
    sel_log.delete(); data_log.delete();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) in_valid = '0;
      check("no_bubble", out_valid, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("fair_count", sel_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("fair_sel", sel_log[i], fair_sel[i]);
      check("fair_data", data_log[i], 8'hA0 + fair_sel[i]);
    end

    // Wrap: ptr is now 2, only channels 3 and 1 request.
    sel_log.delete(); data_log.delete();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1 in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_count", sel_log.size(), 4);
    for (int i = 0; i < 4; i++) check("wrap_sel", sel_log[i], wrap_sel[i]);

    // Backpressure: 10 words each on channels 0 and 2, random out_ready.
    sel_log.delete(); data_log.delete();
    base_cnt = popped;
    for (int i = 0; i < N; i++) begin issued[i] = 0; next_seq[i] = 0; end
    for (int cyc = 0; cyc < 2000 && (popped - base_cnt) < 20; cyc++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        c = j * 2;
        if (in_valid[c] && m_last_ch == c) in_valid[c] = 1'b0;
        if (!in_valid[c] && issued[c] < 10 && $urandom_range(0, 3) != 0) begin
          in_data[c*W +: W] = W'(((c == 0) ? 8'h10 : 8'h90) + issued[c]);
          in_valid[c] = 1'b1;
          issued[c]++;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = '0;
    check("bp_words", popped - base_cnt, 20);
    for (int i = 0; i < sel_log.size(); i++) begin
      c = int'(sel_log[i]);
      check("bp_order", data_log[i], ((c == 0) ? 8'h10 : (c == 2) ? 8'h90 : 8'hFF) + next_seq[c]);
      next_seq[c]++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Stall hold: out_ready low for 5 edges with every channel valid.
    #1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'hA0 + i);
    g0 = m_ptr;
    in_valid = '1;
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (|(in_valid & in_ready)) acc++;
      if (k > 0) begin
        check("stall_sel", out_sel, g0);
        check("stall_data", out_data, 8'hA0 + g0);
      end
    end
    check("stall_accepted", acc, DEPTH);

    // Release the stall and stream: output and input transfer together every cycle.
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("simul_valid", out_valid, 1);
    end

    // Asynchronous reset mid-cycle with data buffered.
    @(negedge clk); #2;
    check("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 0);
    check("async_out_sel", out_sel, 0);
    check("async_in_ready", in_ready, 0);
    @(posedge clk); #3;
    sel_log.delete(); data_log.delete();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_first_sel", sel_log[0], 0);
    check("post_reset_first_data", data_log[0], 8'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
